// File: rtl/neuron_learn_layer_seq.sv
// Sequential single-layer neuron array: one MAC per cycle for the forward pass, then an optional
// weight-update / back-propagation pass over the same (m, i) order.
module neuron_learn_layer_seq #(
    parameter int unsigned N        = 16,
    parameter int unsigned M        = 40,
    parameter int unsigned DW       = 8,
    parameter int unsigned WW       = 8,
    parameter int unsigned LR_SHIFT = 4,
    parameter int          W_INIT   = 2 ** (WW - 2)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic                        learn_i,
    input  logic [N-1:0][DW-1:0]        in_i,
    input  logic [M-1:0][DW-1:0]        expected_out_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [M-1:0][DW-1:0]        out_o,
    output logic [N-1:0][DW-1:0]        expected_in_o,
    output logic [M-1:0][N-1:0][WW-1:0] weights_o,
    output logic [M-1:0][DW-1:0]        activation_max_o,
    output logic [M-1:0][DW-1:0]        activation_min_o
);

    localparam int unsigned AW  = DW + WW + $clog2(N);
    localparam int unsigned UW  = 2 * DW + WW + 2;
    localparam int unsigned BW  = DW + WW + 2 + $clog2(M);
    localparam int unsigned BSH = WW - 2 + $clog2(M);
    localparam int unsigned MCW = (M > 1) ? $clog2(M) : 1;
    localparam int unsigned NCW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {StIdle, StFwd, StUpd, StDone} state_e;

    state_e state_q, state_d;

    logic [N-1:0][DW-1:0]        in_q;
    logic [M-1:0][DW-1:0]        exp_q;
    logic                        learn_q;
    logic [MCW-1:0]              m_q, m_d;
    logic [NCW-1:0]              i_q, i_d;
    logic signed [AW-1:0]        acc_q;
    logic [M-1:0][DW-1:0]        out_q;
    logic [M-1:0][DW-1:0]        amax_q;
    logic [M-1:0][DW-1:0]        amin_q;
    logic [N-1:0][DW-1:0]        ein_q;
    logic [M-1:0][N-1:0][WW-1:0] w_q;
    logic signed [BW-1:0]        bacc_q [N];

    logic                 last_i, last_m, last_mac;
    logic signed [DW:0]   x_s;
    logic signed [WW-1:0] w_s;
    logic signed [AW-1:0] mac_sum, mac_shr;
    logic [DW-1:0]        out_sat;
    logic signed [DW:0]   err;
    logic signed [UW-1:0] upd_prod, w_sum;
    logic [WW-1:0]        w_new;
    logic signed [BW-1:0] bacc_sum;
    logic [N-1:0][DW-1:0] ein_fin;

    assign last_i   = (i_q == NCW'(N - 1));
    assign last_m   = (m_q == MCW'(M - 1));
    assign last_mac = last_i & last_m;

    assign x_s     = signed'({1'b0, in_q[i_q]});
    assign w_s     = w_q[m_q][i_q];
    assign mac_sum = acc_q + AW'(x_s) * AW'(w_s);
    assign mac_shr = mac_sum >>> (WW - 2);

    always_comb begin
        out_sat = mac_shr[DW-1:0];
        if (mac_shr[AW-1]) begin
            out_sat = '0;
        end else if (|mac_shr[AW-2:DW]) begin
            out_sat = '1;
        end
    end

    // Update pass: err uses the output latched by the forward pass, bacc uses the pre-update weight.
    assign err      = signed'({1'b0, exp_q[m_q]}) - signed'({1'b0, out_q[m_q]});
    assign upd_prod = UW'(err) * UW'(x_s);
    assign w_sum    = UW'(w_s) + (upd_prod >>> (DW + LR_SHIFT));
    assign bacc_sum = bacc_q[i_q] + BW'(err) * BW'(w_s);

    always_comb begin
        w_new = w_sum[WW-1:0];
        if (!((&w_sum[UW-1:WW-1]) || !(|w_sum[UW-1:WW-1]))) begin
            w_new = w_sum[UW-1] ? {1'b1, {(WW - 1){1'b0}}} : {1'b0, {(WW - 1){1'b1}}};
        end
    end

    // Final back-propagated targets; the in-flight accumulation is folded in on the last edge.
    always_comb begin
        logic signed [BW-1:0] bf;
        logic signed [BW-1:0] es;
        bf      = '0;
        es      = '0;
        ein_fin = '0;
        for (int i = 0; i < N; i++) begin
            bf = (i_q == NCW'(i)) ? bacc_sum : bacc_q[i];
            es = BW'(signed'({1'b0, in_q[i]})) + (bf >>> BSH);
            if (es[BW-1]) begin
                ein_fin[i] = '0;
            end else if (|es[BW-2:DW]) begin
                ein_fin[i] = '1;
            end else begin
                ein_fin[i] = es[DW-1:0];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (in_valid_i) state_d = StFwd;
            StFwd:   if (last_mac) state_d = learn_q ? StUpd : StDone;
            StUpd:   if (last_mac) state_d = StDone;
            StDone:  if (out_ready_i) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready_o  = (state_q == StIdle);
        out_valid_o = (state_q == StDone);
    end

    always_comb begin
        i_d = i_q;
        m_d = m_q;
        if (state_q == StIdle) begin
            i_d = '0;
            m_d = '0;
        end else if (state_q == StFwd || state_q == StUpd) begin
            if (last_i) begin
                i_d = '0;
                m_d = last_m ? '0 : m_q + MCW'(1);
            end else begin
                i_d = i_q + NCW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            in_q    <= '0;
            exp_q   <= '0;
            learn_q <= 1'b0;
            m_q     <= '0;
            i_q     <= '0;
            acc_q   <= '0;
            out_q   <= '0;
            amax_q  <= '0;
            amin_q  <= '1;
            ein_q   <= '0;
            for (int m = 0; m < M; m++) begin
                for (int i = 0; i < N; i++) begin
                    w_q[m][i] <= WW'(W_INIT);
                end
            end
            for (int i = 0; i < N; i++) begin
                bacc_q[i] <= '0;
            end
        end else begin
            m_q <= m_d;
            i_q <= i_d;
            case (state_q)
                StIdle: begin
                    if (in_valid_i) begin
                        in_q    <= in_i;
                        exp_q   <= expected_out_i;
                        learn_q <= learn_i;
                        acc_q   <= '0;
                        for (int i = 0; i < N; i++) begin
                            bacc_q[i] <= '0;
                        end
                    end
                end
                StFwd: begin
                    acc_q <= last_i ? '0 : mac_sum;
                    if (last_i) begin
                        out_q[m_q] <= out_sat;
                        if (out_sat > amax_q[m_q]) amax_q[m_q] <= out_sat;
                        if (out_sat < amin_q[m_q]) amin_q[m_q] <= out_sat;
                    end
                end
                StUpd: begin
                    w_q[m_q][i_q] <= w_new;
                    bacc_q[i_q]   <= bacc_sum;
                    if (last_mac) ein_q <= ein_fin;
                end
                default: ;
            endcase
        end
    end

    assign out_o            = out_q;
    assign expected_in_o    = ein_q;
    assign weights_o        = w_q;
    assign activation_max_o = amax_q;
    assign activation_min_o = amin_q;

endmodule

// File: tb/tb_neuron_learn_layer_seq.sv
// Bench for neuron_learn_layer_seq (N=2, M=2): directed vector table, DONE-hold and mid-pass
// reset sequences, then random transactions against an arithmetic reference model.
module tb_neuron_learn_layer_seq;

    localparam int N = 2, M = 2, DW = 8, WW = 8, LR_SHIFT = 4, W_INIT = 64;
    localparam int OSH = WW - 2;
    localparam int USH = DW + LR_SHIFT;
    localparam int BSH = WW - 2 + 1;

    logic clk = 1'b0;
    logic rst, in_valid, in_ready, learn, out_valid, out_ready;
    logic [N-1:0][DW-1:0]        in_v, ein;
    logic [M-1:0][DW-1:0]        exp_v, out, amax, amin;
    logic [M-1:0][N-1:0][WW-1:0] wts;

    int n_chk = 0;
    int n_fail = 0;

    int mw[M][N];
    int mout[M], mamax[M], mamin[M];
    int mei[N];

    always #5 clk = ~clk;

    neuron_learn_layer_seq #(
        .N(N), .M(M), .DW(DW), .WW(WW), .LR_SHIFT(LR_SHIFT), .W_INIT(W_INIT)
    ) dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready), .learn_i(learn),
        .in_i(in_v), .expected_out_i(exp_v), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_o(out), .expected_in_o(ein), .weights_o(wts), .activation_max_o(amax),
        .activation_min_o(amin)
    );

    typedef struct {
        int rst_first; int lrn; int x0; int x1; int e0; int e1; int lat;
        int o0; int o1; int w00; int w01; int w10; int w11; int ei0; int ei1; int amx; int amn;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int clamp(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    task automatic model_reset();
        for (int m = 0; m < M; m++) begin
            for (int i = 0; i < N; i++) mw[m][i] = W_INIT;
            mout[m] = 0; mamax[m] = 0; mamin[m] = 255;
        end
        for (int i = 0; i < N; i++) mei[i] = 0;
    endtask

    // Whole-pass arithmetic: outputs first, then (if learning) all weights and back-prop sums.
    task automatic model_txn(input int lrn, input int x0, input int x1, input int e0, input int e1);
        int x[N], e[M], bacc[N], s, err;
        x[0] = x0; x[1] = x1; e[0] = e0; e[1] = e1;
        for (int m = 0; m < M; m++) begin
            s = 0;
            for (int i = 0; i < N; i++) s += x[i] * mw[m][i];
            mout[m] = clamp(s >>> OSH, 0, 255);
            if (mout[m] > mamax[m]) mamax[m] = mout[m];
            if (mout[m] < mamin[m]) mamin[m] = mout[m];
        end
        if (lrn != 0) begin
            for (int i = 0; i < N; i++) bacc[i] = 0;
            for (int m = 0; m < M; m++) begin
                err = e[m] - mout[m];
                for (int i = 0; i < N; i++) begin
                    bacc[i] += err * mw[m][i];
                    mw[m][i] = clamp(mw[m][i] + ((err * x[i]) >>> USH), -128, 127);
                end
            end
            for (int i = 0; i < N; i++) mei[i] = clamp(x[i] + (bacc[i] >>> BSH), 0, 255);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic start_txn(input int lrn, input int x0, input int x1, input int e0, input int e1,
                             output int lat);
        chk("accept_ready", int'(in_ready), 1);
        in_valid = 1'b1; learn = lrn[0];
        in_v[0] = x0[7:0]; in_v[1] = x1[7:0]; exp_v[0] = e0[7:0]; exp_v[1] = e1[7:0];
        @(posedge clk); #1;
        // Scramble inputs after accept; the pass must not see them.
        in_valid = 1'b0; learn = $urandom_range(0, 1);
        in_v = $urandom; exp_v = $urandom;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic finish_txn();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("back_to_idle", int'(in_ready), 1);
    endtask

    task automatic check_model(input string tag);
        for (int m = 0; m < M; m++) begin
            chk($sformatf("%s out[%0d]", tag, m), int'(out[m]), mout[m]);
            chk($sformatf("%s amax[%0d]", tag, m), int'(amax[m]), mamax[m]);
            chk($sformatf("%s amin[%0d]", tag, m), int'(amin[m]), mamin[m]);
            for (int i = 0; i < N; i++)
                chk($sformatf("%s w[%0d][%0d]", tag, m, i), $signed(wts[m][i]), mw[m][i]);
        end
        for (int i = 0; i < N; i++)
            chk($sformatf("%s ein[%0d]", tag, i), int'(ein[i]), mei[i]);
    endtask

    initial begin
        int lat, lrn, x0, x1, e0, e1;
        vecs[0] = '{1, 0, 100,  50,   0,   0, 4, 150, 150, 64, 64, 64, 64,   0,   0, 150, 150};
        vecs[1] = '{0, 0, 200, 200,   0,   0, 4, 255, 255, 64, 64, 64, 64,   0,   0, 255, 150};
        vecs[2] = '{0, 1, 100,  50, 200, 200, 8, 150, 150, 65, 64, 65, 64, 150, 100, 255, 150};
        vecs[3] = '{1, 1, 100,  50,   0,   0, 8, 150, 150, 60, 62, 60, 62,   0,   0, 150, 150};

        in_valid = 1'b0; out_ready = 1'b0; learn = 1'b0; in_v = '0; exp_v = '0;
        do_reset();
        chk("rst in_ready", int'(in_ready), 1);
        chk("rst out_valid", int'(out_valid), 0);
        chk("rst out", int'(out), 0);
        chk("rst ein", int'(ein), 0);
        chk("rst amax", int'(amax), 0);
        chk("rst amin", int'(amin), 16'hffff);
        for (int m = 0; m < M; m++)
            for (int i = 0; i < N; i++)
                chk($sformatf("rst w[%0d][%0d]", m, i), $signed(wts[m][i]), W_INIT);

        foreach (vecs[k]) begin
            if (vecs[k].rst_first != 0) do_reset();
            start_txn(vecs[k].lrn, vecs[k].x0, vecs[k].x1, vecs[k].e0, vecs[k].e1, lat);
            model_txn(vecs[k].lrn, vecs[k].x0, vecs[k].x1, vecs[k].e0, vecs[k].e1);
            chk($sformatf("v%0d latency", k), lat, vecs[k].lat);
            chk($sformatf("v%0d out0", k), int'(out[0]), vecs[k].o0);
            chk($sformatf("v%0d out1", k), int'(out[1]), vecs[k].o1);
            chk($sformatf("v%0d w00", k), $signed(wts[0][0]), vecs[k].w00);
            chk($sformatf("v%0d w01", k), $signed(wts[0][1]), vecs[k].w01);
            chk($sformatf("v%0d w10", k), $signed(wts[1][0]), vecs[k].w10);
            chk($sformatf("v%0d w11", k), $signed(wts[1][1]), vecs[k].w11);
            chk($sformatf("v%0d ein0", k), int'(ein[0]), vecs[k].ei0);
            chk($sformatf("v%0d ein1", k), int'(ein[1]), vecs[k].ei1);
            chk($sformatf("v%0d amax0", k), int'(amax[0]), vecs[k].amx);
            chk($sformatf("v%0d amin0", k), int'(amin[0]), vecs[k].amn);
            finish_txn();
        end

        // DONE holds with out_ready low; in_valid is ignored there.
        start_txn(1, 30, 40, 90, 10, lat);
        model_txn(1, 30, 40, 90, 10);
        chk("hold latency", lat, 8);
        in_valid = 1'b1; in_v[0] = 8'd7; in_v[1] = 8'd9;
        repeat (5) begin
            @(posedge clk); #1;
            chk("hold out_valid", int'(out_valid), 1);
            chk("hold in_ready", int'(in_ready), 0);
            check_model("hold");
        end
        in_valid = 1'b0;
        finish_txn();

        for (int t = 0; t < 30; t++) begin
            lrn = $urandom_range(0, 1);
            x0 = $urandom_range(0, 255); x1 = $urandom_range(0, 255);
            e0 = $urandom_range(0, 255); e1 = $urandom_range(0, 255);
            start_txn(lrn, x0, x1, e0, e1, lat);
            model_txn(lrn, x0, x1, e0, e1);
            chk($sformatf("r%0d latency", t), lat, (lrn != 0) ? 2 * M * N : M * N);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            check_model($sformatf("r%0d", t));
            finish_txn();
        end

        // Reset in the middle of the update pass aborts it.
        in_valid = 1'b1; learn = 1'b1; in_v[0] = 8'd120; in_v[1] = 8'd80; exp_v = '0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (M * N + 1) begin
            @(posedge clk); #1;
        end
        chk("mid_upd busy", int'(in_ready), 0);
        do_reset();
        chk("abort in_ready", int'(in_ready), 1);
        chk("abort out_valid", int'(out_valid), 0);
        check_model("abort");
        start_txn(0, 60, 20, 0, 0, lat);
        model_txn(0, 60, 20, 0, 0);
        chk("post_abort latency", lat, M * N);
        check_model("post_abort");
        finish_txn();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/neuron_learn_layer_seq.md
NEURON_LEARN_LAYER_SEQ -- requirements
Module: neuron_learn_layer_seq

Interface
REQ-001 SHALL have parameter N, default 16, inputs per neuron.
REQ-002 SHALL have parameter M, default 40, neurons per layer.
REQ-003 SHALL have parameter DW, default 8, unsigned data width; code x means x/2^DW.
REQ-004 SHALL have parameter WW, default 8, signed weight width; code w means w/2^(WW-2).
REQ-005 SHALL have parameter LR_SHIFT, default 4, learning-rate right shift.
REQ-006 SHALL have parameter W_INIT, default 2^(WW-2), reset value of every weight.
REQ-007 SHALL have one clock and a synchronous, active-high reset: clock in 1, the sole clock; reset in 1, synchronous active-high.
REQ-008 in_valid in 1: request; in_ready out 1: accept possible.
REQ-009 learn in 1: sampled at accept; enables weight update pass.
REQ-010 in in [N-1:0] x DW: input vector, sampled at accept.
REQ-011 expected_out in [M-1:0] x DW: targets, sampled at accept.
REQ-012 out_valid out 1: results ready; out_ready in 1: consumer accepts.
REQ-013 out out [M-1:0] x DW: neuron outputs.
REQ-014 expected_in out [N-1:0] x DW: back-propagated input targets.
REQ-015 weights out [M-1:0][N-1:0] x WW signed: current weights.
REQ-016 activation_max / activation_min out [M-1:0] x DW: per-neuron running max/min of out since reset.

Function
REQ-017 SHALL use states IDLE, FWD, UPD, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-018 IDLE: in_valid&&in_ready -> capture in, expected_out, learn; clear counters m=0,i=0; go FWD.
REQ-019 FWD: one MAC per cycle, m outer, i inner, exactly M*N cycles; acc width DW+WW+clog2(N) signed, no overflow.
REQ-020 At i=N-1 of neuron m: out[m] = saturate((acc + in[N-1]*w[m][N-1]) >>> (WW-2)) to [0, 2^DW-1]; activation_max[m]/activation_min[m] updated with that value same edge.
REQ-021 FWD end: learn=1 -> UPD; learn=0 -> DONE, expected_in unchanged.
REQ-022 UPD: exactly M*N cycles, same order; err[m] = expected_out[m] - out[m], signed DW+1.
REQ-023 UPD per (m,i): w[m][i] <= sat_WW(w[m][i] + ((err[m]*in[i]) >>> (DW+LR_SHIFT))); >>> floors toward minus infinity.
REQ-024 UPD per (m,i): bacc[i] += err[m]*w_old[m][i] (pre-update weight); bacc cleared at accept.
REQ-025 UPD end: expected_in[i] = saturate(in[i] + (bacc[i] >>> (WW-2+clog2(M)))) to [0, 2^DW-1]; go DONE.
REQ-026 DONE: hold out_valid and all outputs stable until out_ready; out_valid&&out_ready -> IDLE next cycle; in_valid ignored in DONE.
REQ-027 Latency: out_valid rises M*N cycles (learn=0) or 2*M*N cycles (learn=1) after the accepting edge.
REQ-028 out, expected_in, weights, activation_* meaningful only while out_valid=1 or in IDLE; may change during FWD/UPD.
REQ-029 Input changes after accept SHALL NOT affect the current pass.

Reset
REQ-030 reset SHALL override all activity, including mid-FWD/UPD, and abort the pass with no partial output.
REQ-031 Reset values: state IDLE, in_ready=1, out_valid=0, out=0, expected_in=0, all weights=W_INIT, activation_max=0, activation_min=2^DW-1, counters and bacc=0.

Verification (N=2, M=2, DW=8, WW=8, LR_SHIFT=4, W_INIT=64)
REQ-032 Forward: learn=0, in=[100,50] -> out_valid after 4 cycles, out=[150,150], weights all 64, activation_max=[150,150], activation_min=[150,150].
REQ-033 Saturation: learn=0, in=[200,200] -> out=[255,255], activation_max=[255,255].
REQ-034 Learn up: learn=1, in=[100,50], expected_out=[200,200] -> out_valid after 8 cycles, weights[m]=[65,64], expected_in=[150,100].
REQ-035 Learn down: fresh reset, learn=1, in=[100,50], expected_out=[0,0] -> weights[m]=[60,62], expected_in=[0,0].
REQ-036 Handshake/reset: hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0; assert reset mid-UPD -> next cycle IDLE, weights all 64, out_valid=0.
